// File: rtl/div_pkg.sv
// Shared types and constants for the divider arbiter.
package div_pkg;

   localparam int unsigned DEF_WIDTH = 16;

   // Truncated to the datapath width at the point of use.
   localparam logic [63:0] DIV_ZERO_RESULT = '1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_READY,
      DONE
   } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_picker #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt_c,
   output logic [PW-1:0]   idx_c
);

   always_comb begin
      logic        found;
      int unsigned j;
      found = 1'b0;
      j     = 0;
      gnt_c = '0;
      idx_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         j = (32'(ptr) + i) % NREQ;
         if (!found && req[PW'(j)]) begin
            found            = 1'b1;
            gnt_c[PW'(j)]    = 1'b1;
            idx_c            = PW'(j);
         end
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider between NREQ clients,
// with divide-by-zero bypass and a watchdog against a hung divider.
module div_arbiter
   import div_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_dividend,
   input  logic [NREQ*WIDTH-1:0] req_divisor,
   output logic [NREQ-1:0]       done,
   output logic [WIDTH-1:0]      result,
   output logic                  err,
   output logic                  div_start,
   output logic [WIDTH-1:0]      dividend,
   output logic [WIDTH-1:0]      divisor,
   input  logic                  Busy,
   input  logic                  Ready,
   input  logic [WIDTH-1:0]      dividerres
);

   localparam int unsigned PW  = $clog2(NREQ);
   localparam int unsigned WDW = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   logic [PW-1:0]     owner_q, owner_d;
   logic [NREQ-1:0]   owner_oh_q, owner_oh_d;
   logic [WIDTH-1:0]  op_a_q, op_a_d;
   logic [WIDTH-1:0]  op_b_q, op_b_d;
   logic [PW-1:0]     rr_q, rr_d;
   logic [WDW-1:0]    wdog_q, wdog_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              err_q, err_d;
   logic              div_start_q, div_start_d;
   logic [WIDTH-1:0]  dividend_q, dividend_d;
   logic [WIDTH-1:0]  divisor_q, divisor_d;
   logic              busy_q, ready_q;
   logic [WIDTH-1:0]  res_q;

   logic [NREQ-1:0]   gnt_c;
   logic [PW-1:0]     idx_c;
   logic [WIDTH-1:0]  sel_a_c, sel_b_c;
   logic              timeout_c;

   rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req   (req),
      .ptr   (rr_q),
      .gnt_c (gnt_c),
      .idx_c (idx_c)
   );

   // Operand mux for the winning client.
   always_comb begin
      sel_a_c = '0;
      sel_b_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_c[i]) begin
            sel_a_c = req_dividend[i*WIDTH +: WIDTH];
            sel_b_c = req_divisor[i*WIDTH +: WIDTH];
         end
      end
   end

   assign timeout_c = (wdog_q == WDW'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      owner_oh_d  = owner_oh_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      rr_d        = rr_q;
      wdog_d      = wdog_q;
      done_d      = '0;
      result_d    = result_q;
      err_d       = err_q;
      div_start_d = 1'b0;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               owner_d    = idx_c;
               owner_oh_d = gnt_c;
               op_a_d     = sel_a_c;
               op_b_d     = sel_b_c;
               if (sel_b_c == '0) begin
                  state_d  = DONE;
                  done_d   = gnt_c;
                  result_d = WIDTH'(DIV_ZERO_RESULT);
                  err_d    = 1'b1;
               end else begin
                  state_d = ISSUE;
                  wdog_d  = '0;
               end
            end
         end
         ISSUE: begin
            wdog_d = '0;
            if (!busy_q) begin
               div_start_d = 1'b1;
               dividend_d  = op_a_q;
               divisor_d   = op_b_q;
               state_d     = WAIT_BUSY;
            end
         end
         WAIT_BUSY, WAIT_READY: begin
            wdog_d = wdog_q + WDW'(1);
            if (ready_q) begin
               state_d  = DONE;
               done_d   = owner_oh_q;
               result_d = res_q;
               err_d    = 1'b0;
            end else if (timeout_c) begin
               state_d  = DONE;
               done_d   = owner_oh_q;
               result_d = '0;
               err_d    = 1'b1;
            end else if (state_q == WAIT_BUSY && busy_q) begin
               state_d = WAIT_READY;
            end
         end
         DONE: begin
            state_d = IDLE;
            rr_d    = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         owner_oh_q  <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rr_q        <= '0;
         wdog_q      <= '0;
         done_q      <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         div_start_q <= 1'b0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
         res_q       <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         owner_oh_q  <= owner_oh_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         rr_q        <= rr_d;
         wdog_q      <= wdog_d;
         done_q      <= done_d;
         result_q    <= result_d;
         err_q       <= err_d;
         div_start_q <= div_start_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         busy_q      <= Busy;
         ready_q     <= Ready;
         res_q       <= dividerres;
      end
   end

   assign done      = done_q;
   assign result    = result_q;
   assign err       = err_q;
   assign div_start = div_start_q;
   assign dividend  = dividend_q;
   assign divisor   = divisor_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural sequential divider model.
module tb_div_arbiter;

   localparam int unsigned W  = 16;
   localparam int unsigned N  = 4;
   localparam int unsigned TO = 1023;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req = '0;
   logic [N*W-1:0]   req_dividend = '0;
   logic [N*W-1:0]   req_divisor  = '0;
   logic [N-1:0]     done;
   logic [W-1:0]     result;
   logic             err;
   logic             div_start;
   logic [W-1:0]     dividend;
   logic [W-1:0]     divisor;
   logic             busy_w;
   logic             ready_w;
   logic [W-1:0]     dividerres_w;

   // Divider model state
   logic             m_busy  = 1'b0;
   logic             m_ready = 1'b0;
   logic [W-1:0]     m_res   = '0;
   logic [W-1:0]     m_a     = '0;
   logic [W-1:0]     m_b     = '0;
   int               m_cnt   = 0;
   int               m_lat   = 18;
   bit               hang    = 1'b0;
   bit               force_busy = 1'b0;

   int               n_vec = 0;
   int               n_err = 0;
   int               start_cnt = 0;
   int               done_cnt  = 0;
   int               multi_cnt = 0;
   logic [W-1:0]     s_a = '0;
   logic [W-1:0]     s_b = '0;

   logic [N-1:0]     d;
   logic [W-1:0]     r;
   logic             e;
   int               lat, s0, d0;
   logic [W-1:0]     fq [4];

   always #5 clk = ~clk;

   div_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_dividend (req_dividend),
      .req_divisor  (req_divisor),
      .done         (done),
      .result       (result),
      .err          (err),
      .div_start    (div_start),
      .dividend     (dividend),
      .divisor      (divisor),
      .Busy         (busy_w),
      .Ready        (ready_w),
      .dividerres   (dividerres_w)
   );

   assign busy_w       = m_busy | force_busy;
   assign ready_w      = m_ready;
   assign dividerres_w = m_res;

   // Sequential divider: busy for m_lat cycles after start, then a one-cycle ready.
   always @(posedge clk) begin
      m_ready <= 1'b0;
      if (div_start && !m_busy) begin
         m_busy <= 1'b1;
         m_cnt  <= m_lat;
         m_a    <= dividend;
         m_b    <= divisor;
      end else if (m_busy && !hang) begin
         if (m_cnt <= 1) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b1;
            m_res   <= (m_b != '0) ? m_a / m_b : '1;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (div_start) begin
         start_cnt <= start_cnt + 1;
         s_a       <= dividend;
         s_b       <= divisor;
      end
      if (done != '0) done_cnt <= done_cnt + 1;
      if ($countones(done) > 1) multi_cnt <= multi_cnt + 1;
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_dividend[i*W +: W] = a;
      req_divisor[i*W +: W]  = b;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc(1);
   endtask

   task automatic wait_done(input int maxc, output logic [N-1:0] dd, output logic [W-1:0] rr,
                            output logic ee, output int ll);
      dd = '0; rr = '0; ee = 1'b0; ll = 0;
      while (ll < maxc && dd == '0) begin
         @(negedge clk);
         ll++;
         if (done != '0) begin
            dd = done;
            rr = result;
            ee = err;
         end
      end
      chk_eq("done_seen", 32'(dd != '0), 32'd1);
   endtask

   initial begin
      fq[0] = 16'd14; fq[1] = 16'd22; fq[2] = 16'd27; fq[3] = 16'd30;

      // Reset state
      #2 rst = 1'b0;
      cyc(2);
      chk_eq("rst_done", 32'(done), 32'd0);
      chk_eq("rst_result", 32'(result), 32'd0);
      chk_eq("rst_err", 32'(err), 32'd0);
      chk_eq("rst_start", 32'(div_start), 32'd0);
      chk_eq("rst_dividend", 32'(dividend), 32'd0);
      chk_eq("rst_divisor", 32'(divisor), 32'd0);
      rst = 1'b1;
      cyc(2);

      // Single request 7372/100
      m_lat = 18;
      set_op(0, 16'd7372, 16'd100);
      s0 = start_cnt;
      req = 4'b0001;
      wait_done(200, d, r, e, lat);
      req = '0;
      chk_eq("single_done", 32'(d), 32'h1);
      chk_eq("single_result", 32'(r), 32'd73);
      chk_eq("single_err", 32'(e), 32'd0);
      chk_eq("single_starts", 32'(start_cnt - s0), 32'd1);
      chk_eq("single_dividend", 32'(s_a), 32'd7372);
      chk_eq("single_divisor", 32'(s_b), 32'd100);
      cyc(3);
      chk_eq("single_hold", 32'(result), 32'd73);
      chk_eq("single_pulse", 32'(done), 32'd0);

      // Fairness with all four clients requesting
      do_reset();
      m_lat = 3;
      set_op(0, 16'd100, 16'd7);
      set_op(1, 16'd200, 16'd9);
      set_op(2, 16'd300, 16'd11);
      set_op(3, 16'd400, 16'd13);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_done(100, d, r, e, lat);
         chk_eq("fair_done", 32'(d), 32'd1 << (k % 4));
         chk_eq("fair_result", 32'(r), 32'(fq[k % 4]));
      end
      req = '0;
      cyc(5);

      // Divide-by-zero on client 2
      set_op(2, 16'd1234, 16'd0);
      s0 = start_cnt;
      req = 4'b0100;
      wait_done(10, d, r, e, lat);
      req = '0;
      chk_eq("dz_latency", 32'(lat), 32'd1);
      chk_eq("dz_done", 32'(d), 32'h4);
      chk_eq("dz_result", 32'(r), 32'hFFFF);
      chk_eq("dz_err", 32'(e), 32'd1);
      cyc(3);
      chk_eq("dz_no_start", 32'(start_cnt - s0), 32'd0);

      // Busy already high when client 1 is granted
      set_op(1, 16'd5000, 16'd7);
      force_busy = 1'b1;
      s0 = start_cnt;
      req = 4'b0010;
      cyc(10);
      chk_eq("busy_held_off", 32'(start_cnt - s0), 32'd0);
      force_busy = 1'b0;
      wait_done(100, d, r, e, lat);
      req = '0;
      chk_eq("busy_done", 32'(d), 32'h2);
      chk_eq("busy_result", 32'(r), 32'd714);
      chk_eq("busy_err", 32'(e), 32'd0);
      chk_eq("busy_starts", 32'(start_cnt - s0), 32'd1);
      cyc(3);

      // Hung divider; client 0 pending behind client 3
      m_lat = 5;
      hang  = 1'b1;
      set_op(3, 16'd900, 16'd9);
      set_op(0, 16'd800, 16'd16);
      s0 = start_cnt;
      req = 4'b1001;
      wait_done(1100, d, r, e, lat);
      req = 4'b0001;
      chk_eq("hung_latency", 32'(lat), 32'(TO + 2));
      chk_eq("hung_done", 32'(d), 32'h8);
      chk_eq("hung_result", 32'(r), 32'd0);
      chk_eq("hung_err", 32'(e), 32'd1);
      cyc(30);
      chk_eq("hung_no_issue", 32'(start_cnt - s0), 32'd1);
      hang = 1'b0;
      wait_done(100, d, r, e, lat);
      req = '0;
      chk_eq("recov_done", 32'(d), 32'h1);
      chk_eq("recov_result", 32'(r), 32'd50);
      chk_eq("recov_err", 32'(e), 32'd0);
      chk_eq("recov_starts", 32'(start_cnt - s0), 32'd2);
      cyc(3);

      // Asynchronous reset while waiting for Ready
      m_lat = 30;
      set_op(0, 16'd3000, 16'd3);
      req = 4'b0001;
      cyc(12);
      rst = 1'b0;
      req = '0;
      #1;
      chk_eq("arst_done", 32'(done), 32'd0);
      chk_eq("arst_result", 32'(result), 32'd0);
      chk_eq("arst_err", 32'(err), 32'd0);
      chk_eq("arst_start", 32'(div_start), 32'd0);
      chk_eq("arst_dividend", 32'(dividend), 32'd0);
      chk_eq("arst_divisor", 32'(divisor), 32'd0);
      cyc(2);
      rst = 1'b1;
      d0 = done_cnt;
      cyc(40);
      chk_eq("arst_no_done", 32'(done_cnt - d0), 32'd0);
      m_lat = 4;
      set_op(3, 16'd999, 16'd3);
      req = 4'b1000;
      wait_done(200, d, r, e, lat);
      req = '0;
      chk_eq("post_rst_done", 32'(d), 32'h8);
      chk_eq("post_rst_result", 32'(r), 32'd333);
      chk_eq("post_rst_err", 32'(e), 32'd0);
      cyc(3);

      chk_eq("never_multi_hot", 32'(multi_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
